// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - shared state, opcode and datapath select encodings for the LC-3 control unit
package lc3_pkg;

    typedef enum logic [4:0] {
        S_HALTED, S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
        S_ADD, S_AND, S_NOT, S_BR, S_JMP,
        S_JSR1, S_JSR2, S_LDR1, S_LDR2, S_LDR3,
        S_STR1, S_STR2, S_STR3, S_PAUSE1, S_PAUSE2
    } state_t;

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    localparam logic [1:0] PCMUX_INC  = 2'b00;
    localparam logic [1:0] PCMUX_BUS  = 2'b01;
    localparam logic [1:0] PCMUX_ADDR = 2'b10;

    localparam logic [1:0] ADDR2_ZERO  = 2'b00;
    localparam logic [1:0] ADDR2_OFF6  = 2'b01;
    localparam logic [1:0] ADDR2_OFF9  = 2'b10;
    localparam logic [1:0] ADDR2_OFF11 = 2'b11;

    localparam logic [1:0] ALUK_ADD  = 2'b00;
    localparam logic [1:0] ALUK_AND  = 2'b01;
    localparam logic [1:0] ALUK_NOT  = 2'b10;
    localparam logic [1:0] ALUK_PASS = 2'b11;

endpackage

// File: rtl/lc3_mem_wait.sv
// rtl/lc3_mem_wait.sv - memory wait-state counter; done marks the last cycle of a MEM_WAIT-long strobe
module lc3_mem_wait #(
    parameter int MEM_WAIT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic busy,
    output logic done
);

    localparam int CW = $clog2(MEM_WAIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // start is raised on the cycle that enters a wait state, so the count is 0 on its first cycle
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (busy) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = busy && (cnt_q == CW'(MEM_WAIT - 1));

endmodule

// File: rtl/lc3_control_fsm.sv
// rtl/lc3_control_fsm.sv - LC-3 fetch/decode/execute sequencer driving datapath loads, gates and selects
module lc3_control_fsm
    import lc3_pkg::*;
#(
    parameter int MEM_WAIT = 2
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       MIO_EN,
    output logic [1:0] PCMUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_OE,
    output logic       Mem_WE
);

    state_t state_q, state_d;
    logic   wait_start, wait_busy, wait_done;

    assign wait_busy  = state_q inside {S_FETCH2, S_LDR2, S_STR3};
    assign wait_start = (state_d inside {S_FETCH2, S_LDR2, S_STR3}) && (state_d != state_q);

    lc3_mem_wait #(.MEM_WAIT(MEM_WAIT)) u_mem_wait (
        .clk   (Clk),
        .rst_n (Reset_n),
        .start (wait_start),
        .busy  (wait_busy),
        .done  (wait_done)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_HALTED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        LD_LED     = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        SR2MUX     = 1'b0;
        ADDR1MUX   = 1'b0;
        DRMUX      = 1'b0;
        SR1MUX     = 1'b0;
        MIO_EN     = 1'b0;
        PCMUX      = PCMUX_INC;
        ADDR2MUX   = ADDR2_ZERO;
        ALUK       = ALUK_ADD;
        Mem_OE     = 1'b0;
        Mem_WE     = 1'b0;

        case (state_q)
            S_HALTED: begin
                if (Run) state_d = S_FETCH1;
            end
            S_FETCH1: begin
                GatePC  = 1'b1;
                LD_MAR  = 1'b1;
                LD_PC   = 1'b1;
                PCMUX   = PCMUX_INC;
                state_d = S_FETCH2;
            end
            S_FETCH2, S_LDR2: begin
                Mem_OE = 1'b1;
                MIO_EN = 1'b1;
                LD_MDR = wait_done;
                if (wait_done) state_d = (state_q == S_FETCH2) ? S_FETCH3 : S_LDR3;
            end
            S_FETCH3: begin
                GateMDR = 1'b1;
                LD_IR   = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                LD_BEN = 1'b1;
                case (Opcode)
                    OP_ADD:   state_d = S_ADD;
                    OP_AND:   state_d = S_AND;
                    OP_NOT:   state_d = S_NOT;
                    OP_BR:    state_d = S_BR;
                    OP_JMP:   state_d = S_JMP;
                    OP_JSR:   state_d = S_JSR1;
                    OP_LDR:   state_d = S_LDR1;
                    OP_STR:   state_d = S_STR1;
                    OP_PAUSE: state_d = S_PAUSE1;
                    default:  state_d = S_FETCH1;
                endcase
            end
            S_ADD, S_AND, S_NOT: begin
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                SR2MUX  = IR_5;
                ALUK    = (state_q == S_ADD) ? ALUK_ADD :
                          (state_q == S_AND) ? ALUK_AND : ALUK_NOT;
                state_d = S_FETCH1;
            end
            S_BR: begin
                if (BEN) begin
                    LD_PC    = 1'b1;
                    PCMUX    = PCMUX_ADDR;
                    ADDR2MUX = ADDR2_OFF9;
                end
                state_d = S_FETCH1;
            end
            S_JMP: begin
                LD_PC    = 1'b1;
                PCMUX    = PCMUX_ADDR;
                ADDR1MUX = 1'b1;
                state_d  = S_FETCH1;
            end
            S_JSR1: begin
                GatePC  = 1'b1;
                LD_REG  = 1'b1;
                DRMUX   = 1'b1;
                state_d = S_JSR2;
            end
            S_JSR2: begin
                LD_PC    = 1'b1;
                PCMUX    = PCMUX_ADDR;
                ADDR1MUX = !IR_11;
                ADDR2MUX = IR_11 ? ADDR2_OFF11 : ADDR2_ZERO;
                state_d  = S_FETCH1;
            end
            S_LDR1, S_STR1: begin
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
                ADDR1MUX   = 1'b1;
                ADDR2MUX   = ADDR2_OFF6;
                state_d    = (state_q == S_LDR1) ? S_LDR2 : S_STR2;
            end
            S_LDR3: begin
                GateMDR = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                state_d = S_FETCH1;
            end
            // MDR is loaded from the ALU pass-through of SR, not from memory
            S_STR2: begin
                GateALU = 1'b1;
                ALUK    = ALUK_PASS;
                SR1MUX  = 1'b1;
                LD_MDR  = 1'b1;
                state_d = S_STR3;
            end
            S_STR3: begin
                Mem_WE = 1'b1;
                if (wait_done) state_d = S_FETCH1;
            end
            S_PAUSE1: begin
                LD_LED = 1'b1;
                if (Continue) state_d = S_PAUSE2;
            end
            S_PAUSE2: begin
                if (!Continue) state_d = S_FETCH1;
            end
            default: state_d = S_HALTED;
        endcase
    end

endmodule

// File: tb/tb_lc3_control_fsm.sv
// tb/tb_lc3_control_fsm.sv - self-checking bench: two DUTs (MEM_WAIT 2 and 3) against a queue-based microcode model
module tb_lc3_control_fsm;

    localparam logic [24:0] M_LD_MAR  = 25'h1000000;
    localparam logic [24:0] M_LD_MDR  = 25'h0800000;
    localparam logic [24:0] M_LD_IR   = 25'h0400000;
    localparam logic [24:0] M_LD_BEN  = 25'h0200000;
    localparam logic [24:0] M_LD_CC   = 25'h0100000;
    localparam logic [24:0] M_LD_REG  = 25'h0080000;
    localparam logic [24:0] M_LD_PC   = 25'h0040000;
    localparam logic [24:0] M_LD_LED  = 25'h0020000;
    localparam logic [24:0] M_GPC     = 25'h0010000;
    localparam logic [24:0] M_GMDR    = 25'h0008000;
    localparam logic [24:0] M_GALU    = 25'h0004000;
    localparam logic [24:0] M_GMARMUX = 25'h0002000;
    localparam logic [24:0] M_SR2     = 25'h0001000;
    localparam logic [24:0] M_ADDR1   = 25'h0000800;
    localparam logic [24:0] M_DRMUX   = 25'h0000400;
    localparam logic [24:0] M_SR1     = 25'h0000200;
    localparam logic [24:0] M_MIO     = 25'h0000100;
    localparam logic [24:0] PC_10     = 25'h0000080;
    localparam logic [24:0] A2_01     = 25'h0000010;
    localparam logic [24:0] A2_10     = 25'h0000020;
    localparam logic [24:0] A2_11     = 25'h0000030;
    localparam logic [24:0] ALU_01    = 25'h0000004;
    localparam logic [24:0] ALU_10    = 25'h0000008;
    localparam logic [24:0] ALU_11    = 25'h000000C;
    localparam logic [24:0] M_OE      = 25'h0000002;
    localparam logic [24:0] M_WE      = 25'h0000001;
    localparam logic [24:0] FETCH_SIG = M_LD_MAR | M_LD_PC | M_GPC;

    localparam logic [2:0] K_PLAIN = 3'd0, K_DECODE = 3'd1, K_ALU = 3'd2, K_BR = 3'd3, K_JSR2 = 3'd4;

    typedef struct packed {
        logic [2:0]  kind;
        logic [24:0] v;
    } ent_t;

    logic       Clk = 1'b0;
    logic       Reset_n, Run, Continue, IR_5, IR_11, BEN;
    logic [3:0] Opcode;
    logic [24:0] act0, act1;

    ent_t mq [2][$];
    bit   halted [2];
    int   pmode [2];
    int   mw [2];

    int n_cmp = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    lc3_control_fsm #(.MEM_WAIT(2)) u_dut2 (
        .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .Continue(Continue), .Opcode(Opcode),
        .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
        .LD_MAR(act0[24]), .LD_MDR(act0[23]), .LD_IR(act0[22]), .LD_BEN(act0[21]),
        .LD_CC(act0[20]), .LD_REG(act0[19]), .LD_PC(act0[18]), .LD_LED(act0[17]),
        .GatePC(act0[16]), .GateMDR(act0[15]), .GateALU(act0[14]), .GateMARMUX(act0[13]),
        .SR2MUX(act0[12]), .ADDR1MUX(act0[11]), .DRMUX(act0[10]), .SR1MUX(act0[9]),
        .MIO_EN(act0[8]), .PCMUX(act0[7:6]), .ADDR2MUX(act0[5:4]), .ALUK(act0[3:2]),
        .Mem_OE(act0[1]), .Mem_WE(act0[0])
    );

    lc3_control_fsm #(.MEM_WAIT(3)) u_dut3 (
        .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .Continue(Continue), .Opcode(Opcode),
        .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
        .LD_MAR(act1[24]), .LD_MDR(act1[23]), .LD_IR(act1[22]), .LD_BEN(act1[21]),
        .LD_CC(act1[20]), .LD_REG(act1[19]), .LD_PC(act1[18]), .LD_LED(act1[17]),
        .GatePC(act1[16]), .GateMDR(act1[15]), .GateALU(act1[14]), .GateMARMUX(act1[13]),
        .SR2MUX(act1[12]), .ADDR1MUX(act1[11]), .DRMUX(act1[10]), .SR1MUX(act1[9]),
        .MIO_EN(act1[8]), .PCMUX(act1[7:6]), .ADDR2MUX(act1[5:4]), .ALUK(act1[3:2]),
        .Mem_OE(act1[1]), .Mem_WE(act1[0])
    );

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] required);
        n_cmp++;
        if (actual !== required) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, actual, required, $time);
        end
    endtask

    function automatic logic [24:0] eval_ent(input ent_t e);
        case (e.kind)
            K_ALU:   return e.v | (IR_5 ? M_SR2 : 25'h0);
            K_BR:    return BEN ? (M_LD_PC | PC_10 | A2_10) : 25'h0;
            K_JSR2:  return M_LD_PC | PC_10 | (IR_11 ? A2_11 : M_ADDR1);
            default: return e.v;
        endcase
    endfunction

    function automatic ent_t mk(input logic [2:0] k, input logic [24:0] v);
        ent_t e;
        e.kind = k;
        e.v    = v;
        return e;
    endfunction

    task automatic push_fetch(input int g);
        mq[g].push_back(mk(K_PLAIN, FETCH_SIG));
        for (int i = 0; i < mw[g]; i++)
            mq[g].push_back(mk(K_PLAIN, M_OE | M_MIO | ((i == mw[g] - 1) ? M_LD_MDR : 25'h0)));
        mq[g].push_back(mk(K_PLAIN, M_GMDR | M_LD_IR));
        mq[g].push_back(mk(K_DECODE, M_LD_BEN));
    endtask

    task automatic dispatch(input int g);
        logic [24:0] alu = M_GALU | M_LD_REG | M_LD_CC;
        logic [24:0] ea  = M_GMARMUX | M_LD_MAR | M_ADDR1 | A2_01;
        case (Opcode)
            4'b0001: mq[g].push_back(mk(K_ALU, alu));
            4'b0101: mq[g].push_back(mk(K_ALU, alu | ALU_01));
            4'b1001: mq[g].push_back(mk(K_ALU, alu | ALU_10));
            4'b0000: mq[g].push_back(mk(K_BR, 25'h0));
            4'b1100: mq[g].push_back(mk(K_PLAIN, M_LD_PC | PC_10 | M_ADDR1));
            4'b0100: begin
                mq[g].push_back(mk(K_PLAIN, M_GPC | M_LD_REG | M_DRMUX));
                mq[g].push_back(mk(K_JSR2, 25'h0));
            end
            4'b0110: begin
                mq[g].push_back(mk(K_PLAIN, ea));
                for (int i = 0; i < mw[g]; i++)
                    mq[g].push_back(mk(K_PLAIN, M_OE | M_MIO | ((i == mw[g] - 1) ? M_LD_MDR : 25'h0)));
                mq[g].push_back(mk(K_PLAIN, M_GMDR | M_LD_REG | M_LD_CC));
            end
            4'b0111: begin
                mq[g].push_back(mk(K_PLAIN, ea));
                mq[g].push_back(mk(K_PLAIN, M_GALU | ALU_11 | M_SR1 | M_LD_MDR));
                for (int i = 0; i < mw[g]; i++) mq[g].push_back(mk(K_PLAIN, M_WE));
            end
            4'b1101: pmode[g] = 1;
            default: ;
        endcase
    endtask

    // Compare the current cycle against the model, then advance the model with the inputs the DUT will see at the next edge.
    task automatic model_cycle();
        logic [24:0] exp_v, a;
        ent_t e;
        for (int g = 0; g < 2; g++) begin
            a = (g == 0) ? act0 : act1;
            if (!Reset_n) begin
                halted[g] = 1'b1;
                pmode[g]  = 0;
                mq[g].delete();
                chk(g == 0 ? "model_reset_w2" : "model_reset_w3", {7'd0, a}, 32'd0);
                continue;
            end
            if (halted[g])             exp_v = 25'h0;
            else if (mq[g].size() > 0) exp_v = eval_ent(mq[g][0]);
            else if (pmode[g] == 1)    exp_v = M_LD_LED;
            else                       exp_v = 25'h0;
            chk(g == 0 ? "model_w2" : "model_w3", {7'd0, a}, {7'd0, exp_v});
            chk(g == 0 ? "oe_we_excl_w2" : "oe_we_excl_w3", {31'd0, a[1] & a[0]}, 32'd0);
            if (halted[g]) begin
                if (Run) begin
                    halted[g] = 1'b0;
                    push_fetch(g);
                end
            end else if (mq[g].size() > 0) begin
                e = mq[g].pop_front();
                if (e.kind == K_DECODE) dispatch(g);
                if (mq[g].size() == 0 && pmode[g] == 0) push_fetch(g);
            end else if (pmode[g] == 1) begin
                if (Continue) pmode[g] = 2;
            end else if (pmode[g] == 2) begin
                if (!Continue) begin
                    pmode[g] = 0;
                    push_fetch(g);
                end
            end
        end
    endtask

    task automatic step();
        @(negedge Clk);
        model_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic run_op(input logic [3:0] op, input int n);
        Opcode = op;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int n, oe, mdr, cnt;
        bit found;
        logic [24:0] last;
        mw[0] = 2;
        mw[1] = 3;
        Reset_n = 1'b0; Run = 1'b0; Continue = 1'b0; Opcode = 4'b0001;
        IR_5 = 1'b1; IR_11 = 1'b0; BEN = 1'b0;
        step();
        step();
        chk("reset_outputs_w2", {7'd0, act0}, 32'd0);
        Reset_n = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("halted_no_run_w3", {7'd0, act1}, 32'd0);

        Run = 1'b1;
        step();
        Run = 1'b0;
        chk("fetch1_after_run", {7'd0, act0}, {7'd0, FETCH_SIG});
        n = 1; oe = 0; mdr = 0; last = act0;
        while (n < 20) begin
            step();
            if ((act0 & FETCH_SIG) == FETCH_SIG) break;
            n++;
            oe  += int'(act0[1]);
            mdr += int'(act0[23]);
            last = act0;
        end
        chk("add_instr_cycles", n, 6);
        chk("add_fetch_oe_cycles", oe, 2);
        chk("add_fetch_mdr_cycles", mdr, 1);
        chk("add_exec_outputs", {7'd0, last}, 32'h0185000);

        IR_5 = 1'b0;
        run_op(4'b0101, 20);
        IR_5 = 1'b1;
        run_op(4'b1001, 20);
        run_op(4'b1111, 20);

        BEN = 1'b1;
        Opcode = 4'b0000;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (act0 == (M_LD_PC | PC_10 | A2_10)) found = 1'b1;
        end
        chk("br_taken_seen", {31'd0, found}, 32'd1);
        BEN = 1'b0;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (act0[18] && !act0[16]) cnt++;
        end
        chk("br_not_taken_no_pc_load", cnt, 0);

        run_op(4'b1100, 20);

        IR_11 = 1'b1;
        Opcode = 4'b0100;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (act0 == (M_GPC | M_LD_REG | M_DRMUX)) found = 1'b1;
        end
        chk("jsr1_seen", {31'd0, found}, 32'd1);
        step();
        chk("jsr2_outputs", {7'd0, act0}, 32'h00400B0);
        IR_11 = 1'b0;
        run_op(4'b0100, 20);
        run_op(4'b0110, 30);

        Opcode = 4'b0111;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            if (act1[23] && act1[14]) found = 1'b1;
        end
        chk("str2_seen_w3", {31'd0, found}, 32'd1);
        chk("str2_mio_en_w3", {31'd0, act1[8]}, 32'd0);
        step();
        n = 0; oe = 0;
        while (act1[0] && n < 10) begin
            oe += int'(act1[1]);
            n++;
            step();
        end
        chk("str3_we_cycles_w3", n, 3);
        chk("str3_oe_during_we_w3", oe, 0);

        Opcode = 4'b1101;
        Continue = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            if (act0[17] && act1[17]) found = 1'b1;
        end
        chk("pause1_reached", {31'd0, found}, 32'd1);
        for (int i = 0; i < 5; i++) step();
        chk("pause1_holds_w2", {7'd0, act0}, {7'd0, M_LD_LED});
        chk("pause1_holds_w3", {7'd0, act1}, {7'd0, M_LD_LED});
        Continue = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("pause2_holds_w2", {7'd0, act0}, 32'd0);
        Opcode = 4'b0001;
        Continue = 1'b0;
        step();
        chk("pause_release_fetch_w2", {7'd0, act0}, {7'd0, FETCH_SIG});
        chk("pause_release_fetch_w3", {7'd0, act1}, {7'd0, FETCH_SIG});

        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (act0[1]) found = 1'b1;
        end
        chk("fetch2_reached", {31'd0, found}, 32'd1);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("async_reset_w2", {7'd0, act0}, 32'd0);
        chk("async_reset_w3", {7'd0, act1}, 32'd0);
        step();
        Reset_n = 1'b1;
        Run = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (act0 != 25'h0) cnt++;
        end
        chk("halted_after_reset", cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
